// File: rtl/stage_complete_cdb_pkg.sv
// stage_complete_cdb_pkg: shared widths, FU indices and the CDB packet type.
package stage_complete_cdb_pkg;
    localparam int NUM_SRC = 3;
    localparam int XLEN = 32;
    localparam int TAG_W = 6;
    localparam int ROB_W = 5;
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int NUM_FU_ALU = 0;
    localparam int NUM_FU_MULT = 1;
    localparam int NUM_FU_BRANCH = 2;
    localparam logic [TAG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic valid;
        logic [XLEN-1:0] value;
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] rob_idx;
    } cdb_packet_t;

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction
endpackage

// File: rtl/stage_complete_cdb_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting at ptr_i with wrap-around.
module rr_arbiter
    import stage_complete_cdb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        cand = '0;
        gnt_idx_o = '0;
        // Scan farthest-first so the closest requester at or after ptr_i wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'(wrap_add(int'(ptr_i), k, NUM_REQ));
            if (req_i[cand]) gnt_idx_o = cand;
        end
        gnt_o = (|req_i) ? (NUM_REQ'(1) << gnt_idx_o) : '0;
    end
endmodule

// File: rtl/stage_complete_cdb.sv
// stage_complete_cdb: per-source holding slots arbitrated onto a single common data bus.
module stage_complete_cdb
    import stage_complete_cdb_pkg::*;
(
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     squash_i,
    input  logic [NUM_SRC-1:0]       src_valid_i,
    input  logic [NUM_SRC*XLEN-1:0]  src_value_i,
    input  logic [NUM_SRC*TAG_W-1:0] src_tag_i,
    input  logic [NUM_SRC*ROB_W-1:0] src_rob_i,
    output logic [NUM_SRC-1:0]       src_ready_o,
    output logic                     cdb_valid_o,
    output logic [XLEN-1:0]          cdb_value_o,
    output logic [TAG_W-1:0]         cdb_tag_o,
    output logic [ROB_W-1:0]         cdb_rob_o,
    output logic [SRC_W-1:0]         cdb_src_o
);
    cdb_packet_t      slot [NUM_SRC];
    cdb_packet_t      pkt;
    logic [NUM_SRC-1:0] held;
    logic [NUM_SRC-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        cdb_packet_t slot_q, slot_d;
        logic accept;
        assign accept = src_valid_i[g] & src_ready_o[g] & ~squash_i;
        always_comb begin
            slot_d = slot_q;
            slot_d.valid = squash_i ? 1'b0 : accept ? 1'b1 : gnt[g] ? 1'b0 : slot_q.valid;
            if (accept) begin
                slot_d.value = src_value_i[g*XLEN +: XLEN];
                slot_d.tag = src_tag_i[g*TAG_W +: TAG_W];
                slot_d.rob_idx = src_rob_i[g*ROB_W +: ROB_W];
            end
        end
        always_ff @(posedge clock_i) begin
            if (reset_i) slot_q <= '0;
            else slot_q <= slot_d;
        end
        assign slot[g] = slot_q;
        assign held[g] = slot_q.valid;
    end

    rr_arbiter #(.NUM_REQ(NUM_SRC)) u_arb (
        .req_i    (held),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_idx_o(gnt_idx)
    );

    assign rr_ptr_d = (|held && !squash_i) ? SRC_W'(wrap_add(int'(gnt_idx), 1, NUM_SRC)) : rr_ptr_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) rr_ptr_q <= '0;
        else rr_ptr_q <= rr_ptr_d;
    end

    assign pkt = (|held) ? slot[gnt_idx] : '0;
    assign src_ready_o = ~held | gnt;
    assign cdb_valid_o = |held;
    assign cdb_value_o = pkt.value;
    assign cdb_tag_o = pkt.tag;
    assign cdb_rob_o = pkt.rob_idx;
    assign cdb_src_o = (|held) ? gnt_idx : '0;
endmodule

// File: tb/tb_stage_complete_cdb.sv
// tb_stage_complete_cdb: directed vectors against hand-computed CDB expectations.
module tb_stage_complete_cdb;
    import stage_complete_cdb_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     squash;
    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_SRC*XLEN-1:0]  src_value;
    logic [NUM_SRC*TAG_W-1:0] src_tag;
    logic [NUM_SRC*ROB_W-1:0] src_rob;
    logic [NUM_SRC-1:0]       src_ready;
    logic                     cdb_valid;
    logic [XLEN-1:0]          cdb_value;
    logic [TAG_W-1:0]         cdb_tag;
    logic [ROB_W-1:0]         cdb_rob;
    logic [SRC_W-1:0]         cdb_src;
    int checks = 0;
    int failures = 0;

    stage_complete_cdb dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .squash_i   (squash),
        .src_valid_i(src_valid),
        .src_value_i(src_value),
        .src_tag_i  (src_tag),
        .src_rob_i  (src_rob),
        .src_ready_o(src_ready),
        .cdb_valid_o(cdb_valid),
        .cdb_value_o(cdb_value),
        .cdb_tag_o  (cdb_tag),
        .cdb_rob_o  (cdb_rob),
        .cdb_src_o  (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input int value, input int tag, input int rob);
        src_valid[i] = v;
        src_value[i*XLEN +: XLEN] = XLEN'(value);
        src_tag[i*TAG_W +: TAG_W] = TAG_W'(tag);
        src_rob[i*ROB_W +: ROB_W] = ROB_W'(rob);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        squash = 1'b0;
        src_valid = '0;
        src_value = '0;
        src_tag = '0;
        src_rob = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_cdb(input string tag, input int v, input int value, input int src);
        chk({tag, "_valid"}, 64'(cdb_valid), 64'(v));
        chk({tag, "_value"}, 64'(cdb_value), 64'(value));
        chk({tag, "_src"}, 64'(cdb_src), 64'(src));
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 64'(cdb_valid), 0);
        chk("rst_ready", 64'(src_ready), 7);
        chk("rst_value", 64'(cdb_value), 0);
        chk("rst_tag", 64'(cdb_tag), 0);
        chk("rst_rob", 64'(cdb_rob), 0);
        chk("rst_src", 64'(cdb_src), 0);

        drive(0, 1, 13, 5, 2);
        step();
        drive(0, 0, 0, 0, 0);
        chk_cdb("alu", 1, 13, 0);
        chk("alu_tag", 64'(cdb_tag), 5);
        chk("alu_rob", 64'(cdb_rob), 2);
        step();
        chk("alu_drain", 64'(cdb_valid), 0);

        do_reset();
        drive(0, 1, 7, 1, 1);
        drive(1, 1, 18, 2, 2);
        drive(2, 1, 40, 3, 3);
        step();
        src_valid = '0;
        chk_cdb("all0", 1, 7, 0);
        chk("all0_ready", 64'(src_ready), 1);
        step();
        chk_cdb("all1", 1, 18, 1);
        chk("all1_ready", 64'(src_ready), 3);
        step();
        chk_cdb("all2", 1, 40, 2);
        chk("all2_ready", 64'(src_ready), 7);
        step();
        chk("all_drain", 64'(cdb_valid), 0);

        do_reset();
        drive(0, 1, 1, 4, 4);
        drive(1, 1, 99, 9, 9);
        step();
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 2, 4, 5);
        chk_cdb("b2b1", 1, 1, 0);
        chk("b2b1_rdy", 64'(src_ready[0]), 1);
        step();
        drive(0, 1, 3, 4, 6);
        chk_cdb("b2b2", 1, 99, 1);
        chk("b2b2_rdy", 64'(src_ready[0]), 0);
        step();
        chk_cdb("b2b3", 1, 2, 0);
        chk("b2b3_rdy", 64'(src_ready[0]), 1);
        step();
        drive(0, 1, 4, 4, 7);
        chk_cdb("b2b4", 1, 3, 0);
        chk("b2b4_rdy", 64'(src_ready[0]), 1);
        step();
        drive(0, 0, 0, 0, 0);
        chk_cdb("b2b5", 1, 4, 0);
        chk("b2b5_rob", 64'(cdb_rob), 7);
        step();
        chk("b2b_drain", 64'(cdb_valid), 0);

        do_reset();
        drive(1, 1, 5, 1, 1);
        drive(2, 1, 6, 2, 2);
        step();
        drive(1, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0);
        drive(0, 1, 77, 3, 3);
        squash = 1'b1;
        chk("sq_pre_valid", 64'(cdb_valid), 1);
        step();
        squash = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("sq_valid", 64'(cdb_valid), 0);
        chk("sq_ready", 64'(src_ready), 7);
        step();
        chk("sq_lost_alu", 64'(cdb_valid), 0);

        do_reset();
        drive(0, 1, 55, 0, 3);
        step();
        drive(0, 0, 0, 0, 0);
        chk_cdb("zero", 1, 55, 0);
        chk("zero_tag", 64'(cdb_tag), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
